add_sub_arbiter: RTL

- Sequences and shares one adder_sub_4bit datapath between two requesters (port 0, port 1).
- Uses a round-robin req/done handshake, latched operands and a registered result with carry-out and signed overflow.
- Sits between requesting controllers and the single shared add/sub unit, which it instantiates internally.

---
 rtl/add_sub_arbiter_if.sv | 30 +++
 rtl/add_sub_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/add_sub_arbiter_if.sv
// Request/grant/result bundle between two requesting controllers and the
// shared add/sub arbiter.
interface add_sub_arbiter_if;
    logic       req0;
    logic [3:0] a0;
    logic [3:0] b0;
    logic       sel0;
    logic       req1;
    logic [3:0] a1;
    logic [3:0] b1;
    logic       sel1;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic [3:0] res_s;
    logic       res_cout;
    logic       res_ovf;
    logic       busy;

    modport slave (
        input  req0, a0, b0, sel0, req1, a1, b1, sel1,
        output gnt0, gnt1, done0, done1, res_s, res_cout, res_ovf, busy
    );

    modport master (
        output req0, a0, b0, sel0, req1, a1, b1, sel1,
        input  gnt0, gnt1, done0, done1, res_s, res_cout, res_ovf, busy
    );
endinterface

// File: rtl/add_sub_arbiter.sv
// Round-robin arbiter sharing one 4-bit add/sub datapath between two
// requesters: IDLE latches the winner's operands, EXEC registers the result, DONE pulses done.
module adder_sub_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       sel_i,
    output logic [3:0] s_o,
    output logic       cout_o
);
    logic [3:0] b_eff;

    // Subtraction is A + ~B + 1, so cout=1 means no borrow.
    assign b_eff           = b_i ^ {4{sel_i}};
    assign {cout_o, s_o}   = {1'b0, a_i} + {1'b0, b_eff} + {4'b0000, sel_i};
endmodule

module add_sub_arbiter #(
    parameter bit PRIO_RESET = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    add_sub_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic       prio_q, prio_d;
    logic       owner_q, owner_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic       sel_q, sel_d;
    logic [3:0] res_s_q, res_s_d;
    logic       res_cout_q, res_cout_d;
    logic       res_ovf_q, res_ovf_d;

    logic [3:0] add_s;
    logic       add_cout;

    adder_sub_4bit u_adder (
        .a_i    (a_q),
        .b_i    (b_q),
        .sel_i  (sel_q),
        .s_o    (add_s),
        .cout_o (add_cout)
    );

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path leaves a latch.
        state_d    = state_q;
        prio_d     = prio_q;
        owner_d    = owner_q;
        a_d        = a_q;
        b_d        = b_q;
        sel_d      = sel_q;
        res_s_d    = res_s_q;
        res_cout_d = res_cout_q;
        res_ovf_d  = res_ovf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    owner_d = (bus.req0 && bus.req1) ? prio_q : bus.req1;
                    a_d     = owner_d ? bus.a1   : bus.a0;
                    b_d     = owner_d ? bus.b1   : bus.b0;
                    sel_d   = owner_d ? bus.sel1 : bus.sel0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_s_d    = add_s;
                res_cout_d = add_cout;
                res_ovf_d  = (sel_q ? (a_q[3] != b_q[3]) : (a_q[3] == b_q[3]))
                             && (add_s[3] != a_q[3]);
                state_d    = DONE;
            end
            DONE: begin
                prio_d  = ~prio_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prio_q     <= PRIO_RESET;
            owner_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sel_q      <= 1'b0;
            res_s_q    <= '0;
            res_cout_q <= 1'b0;
            res_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            owner_q    <= owner_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sel_q      <= sel_d;
            res_s_q    <= res_s_d;
            res_cout_q <= res_cout_d;
            res_ovf_q  <= res_ovf_d;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.gnt0     = (state_q != IDLE) && !owner_q;
    assign bus.gnt1     = (state_q != IDLE) &&  owner_q;
    assign bus.done0    = (state_q == DONE) && !owner_q;
    assign bus.done1    = (state_q == DONE) &&  owner_q;
    assign bus.res_s    = res_s_q;
    assign bus.res_cout = res_cout_q;
    assign bus.res_ovf  = res_ovf_q;
endmodule
